// File: rtl/rtc_alarm_host.sv
// RTC alarm register host: alarm compare regs, snapshot handshake to the irq controller, irq_o. Optional RTC_ALARM_HOST_ERR_EN adds rsp_err_o and a read-while-busy counter.
// Latency: response 1 cycle after acceptance, 3 cycles for a snapshot write.
// Backpressure: one transaction in flight; req_ready_o low until the response is taken via rsp_ready_i.
module rtc_alarm_host (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [2:0]  req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic [5:0]  alarm_sec_o,
   output logic [5:0]  alarm_min_o,
   output logic [5:0]  alarm_hour_o,
   output logic [1:0]  alarm_mode_o,
   output logic [2:0]  alarm_day_of_week_o,
   output logic [4:0]  alarm_day_of_month_o,
   output logic [3:0]  alarm_month_o,
   output logic [11:0] alarm_year_o,
   input  logic        irq_match_i,
   output logic        snap_req_o,
   input  logic [5:0]  snap_sec_i,
   input  logic [5:0]  snap_min_i,
   input  logic [5:0]  snap_hour_i,
   input  logic [1:0]  snap_mode_i,
   input  logic [2:0]  snap_day_of_week_i,
   input  logic [4:0]  snap_day_of_month_i,
   input  logic [3:0]  snap_month_i,
   input  logic [11:0] snap_year_i,
   output logic        irq_o
`ifdef RTC_ALARM_HOST_ERR_EN
   ,
   output logic        rsp_err_o
`endif
);

   localparam logic [2:0] A_TIME  = 3'd0;
   localparam logic [2:0] A_DATE  = 3'd1;
   localparam logic [2:0] A_CTRL  = 3'd2;
   localparam logic [2:0] A_STAT  = 3'd3;
   localparam logic [2:0] A_STIME = 3'd4;
   localparam logic [2:0] A_SDATE = 3'd5;
   localparam logic [2:0] A_BUSY  = 3'd6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SNAP_REQ,
      ST_SNAP_WAIT,
      ST_RESP
   } state_t;

   state_t      state_q, state_d;
   logic        live_q, live_d;
   logic [22:0] time_q, time_d;
   logic [20:0] date_q, date_d;
   logic        en_q, en_d;
   logic        pend_q, pend_d;
   logic        snapv_q, snapv_d;
   logic [22:0] stime_q, stime_d;
   logic [20:0] sdate_q, sdate_d;
   logic [31:0] rdata_q, rdata_d;
   logic        match_q, match_d;
   logic        irq_q, irq_d;
`ifdef RTC_ALARM_HOST_ERR_EN
   logic        err_q, err_d;
   logic [3:0]  busy_q, busy_d;
`endif

   logic        accept;
   logic        wr;
   logic        rise;
   logic [31:0] rd_val;
   logic        unused_w;

   assign unused_w = ^req_wdata_i[31:23];

   // live_q keeps ready low through reset and the first clock after release
   assign req_ready_o = live_q & (state_q == ST_IDLE);
   assign rsp_valid_o = (state_q == ST_RESP);
   assign snap_req_o  = (state_q == ST_SNAP_REQ);
   assign rsp_rdata_o = rdata_q;
   assign irq_o       = irq_q;
`ifdef RTC_ALARM_HOST_ERR_EN
   assign rsp_err_o   = err_q;
`endif

   assign alarm_sec_o          = time_q[5:0];
   assign alarm_min_o          = time_q[11:6];
   assign alarm_hour_o         = time_q[17:12];
   assign alarm_mode_o         = time_q[19:18];
   assign alarm_day_of_week_o  = time_q[22:20];
   assign alarm_day_of_month_o = date_q[4:0];
   assign alarm_month_o        = date_q[8:5];
   assign alarm_year_o         = date_q[20:9];

   assign accept = req_valid_i & req_ready_o;
   assign wr     = accept & req_we_i;
   assign rise   = irq_match_i & ~match_q;

   always_comb begin
      rd_val = '0;
      case (req_addr_i)
         A_TIME:  rd_val = {9'd0, time_q};
         A_DATE:  rd_val = {11'd0, date_q};
         A_CTRL:  rd_val = {31'd0, en_q};
         A_STAT:  rd_val = {30'd0, snapv_q, pend_q};
         A_STIME: rd_val = {9'd0, stime_q};
         A_SDATE: rd_val = {11'd0, sdate_q};
`ifdef RTC_ALARM_HOST_ERR_EN
         A_BUSY:  rd_val = {28'd0, busy_q};
`endif
         default: rd_val = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      live_d  = 1'b1;
      time_d  = time_q;
      date_d  = date_q;
      en_d    = en_q;
      pend_d  = pend_q;
      snapv_d = snapv_q;
      stime_d = stime_q;
      sdate_d = sdate_q;
      rdata_d = rdata_q;
      match_d = irq_match_i;
`ifdef RTC_ALARM_HOST_ERR_EN
      err_d   = err_q;
      busy_d  = busy_q;
      if (req_valid_i && !req_we_i && !req_ready_o && busy_q != 4'hF)
         busy_d = busy_q + 4'd1;
`endif

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               rdata_d = req_we_i ? 32'd0 : rd_val;
`ifdef RTC_ALARM_HOST_ERR_EN
               err_d = (req_addr_i == 3'd7) ||
                       (req_we_i && (req_addr_i == A_STIME || req_addr_i == A_SDATE ||
                                     req_addr_i == A_BUSY));
`endif
               if (wr && req_addr_i == A_CTRL && req_wdata_i[1])
                  state_d = ST_SNAP_REQ;
               else
                  state_d = ST_RESP;
            end
         end
         ST_SNAP_REQ: state_d = ST_SNAP_WAIT;
         ST_SNAP_WAIT: begin
            stime_d = {snap_day_of_week_i, snap_mode_i, snap_hour_i, snap_min_i, snap_sec_i};
            sdate_d = {snap_year_i, snap_month_i, snap_day_of_month_i};
            snapv_d = 1'b1;
            state_d = ST_RESP;
         end
         ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (wr) begin
         case (req_addr_i)
            A_TIME: begin
               time_d  = req_wdata_i[22:0];
               pend_d  = 1'b0;
               snapv_d = 1'b0;
            end
            A_DATE: begin
               date_d  = req_wdata_i[20:0];
               pend_d  = 1'b0;
               snapv_d = 1'b0;
            end
            A_CTRL: en_d = req_wdata_i[0];
            A_STAT: if (req_wdata_i[0]) pend_d = 1'b0;
            default: ;
         endcase
      end

      // a fresh match edge beats any clear in the same cycle
      if (rise && en_q) pend_d = 1'b1;
      irq_d = pend_d & en_d;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= ST_IDLE;
         live_q  <= 1'b0;
         time_q  <= '0;
         date_q  <= '0;
         en_q    <= 1'b0;
         pend_q  <= 1'b0;
         snapv_q <= 1'b0;
         stime_q <= '0;
         sdate_q <= '0;
         rdata_q <= '0;
         match_q <= 1'b0;
         irq_q   <= 1'b0;
`ifdef RTC_ALARM_HOST_ERR_EN
         err_q   <= 1'b0;
         busy_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         live_q  <= live_d;
         time_q  <= time_d;
         date_q  <= date_d;
         en_q    <= en_d;
         pend_q  <= pend_d;
         snapv_q <= snapv_d;
         stime_q <= stime_d;
         sdate_q <= sdate_d;
         rdata_q <= rdata_d;
         match_q <= match_d;
         irq_q   <= irq_d;
`ifdef RTC_ALARM_HOST_ERR_EN
         err_q   <= err_d;
         busy_q  <= busy_d;
`endif
      end
   end

endmodule

// File: tb/tb_rtc_alarm_host.sv
// Randomized bench for rtc_alarm_host against a register-level reference model.
module tb_rtc_alarm_host;

   logic        clk_i = 1'b0;
   logic        rstn_i = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_we_i = 1'b0;
   logic [2:0]  req_addr_i = '0;
   logic [31:0] req_wdata_i = '0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b1;
   logic [31:0] rsp_rdata_o;
   logic [5:0]  alarm_sec_o, alarm_min_o, alarm_hour_o;
   logic [1:0]  alarm_mode_o;
   logic [2:0]  alarm_day_of_week_o;
   logic [4:0]  alarm_day_of_month_o;
   logic [3:0]  alarm_month_o;
   logic [11:0] alarm_year_o;
   logic        irq_match_i = 1'b0;
   logic        snap_req_o;
   logic [5:0]  snap_sec_i = '0, snap_min_i = '0, snap_hour_i = '0;
   logic [1:0]  snap_mode_i = '0;
   logic [2:0]  snap_day_of_week_i = '0;
   logic [4:0]  snap_day_of_month_i = '0;
   logic [3:0]  snap_month_i = '0;
   logic [11:0] snap_year_i = '0;
   logic        irq_o;
`ifdef RTC_ALARM_HOST_ERR_EN
   logic        rsp_err_o;
   logic        last_err;
`endif

   int checks = 0;
   int errors = 0;

   // reference model: architectural register contents
   logic [22:0] m_time;
   logic [20:0] m_date;
   logic        m_en, m_pend, m_snapv;
   logic [22:0] m_stime;
   logic [20:0] m_sdate;

   rtc_alarm_host dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
      .alarm_sec_o(alarm_sec_o), .alarm_min_o(alarm_min_o), .alarm_hour_o(alarm_hour_o),
      .alarm_mode_o(alarm_mode_o), .alarm_day_of_week_o(alarm_day_of_week_o),
      .alarm_day_of_month_o(alarm_day_of_month_o), .alarm_month_o(alarm_month_o),
      .alarm_year_o(alarm_year_o),
      .irq_match_i(irq_match_i), .snap_req_o(snap_req_o),
      .snap_sec_i(snap_sec_i), .snap_min_i(snap_min_i), .snap_hour_i(snap_hour_i),
      .snap_mode_i(snap_mode_i), .snap_day_of_week_i(snap_day_of_week_i),
      .snap_day_of_month_i(snap_day_of_month_i), .snap_month_i(snap_month_i),
      .snap_year_i(snap_year_i),
`ifdef RTC_ALARM_HOST_ERR_EN
      .rsp_err_o(rsp_err_o),
`endif
      .irq_o(irq_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required finish before 500000");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic void model_reset();
      m_time = '0; m_date = '0; m_en = 1'b0; m_pend = 1'b0; m_snapv = 1'b0;
      m_stime = '0; m_sdate = '0;
   endfunction

   function automatic logic [31:0] exp_read(input logic [2:0] a);
      case (a)
         3'd0: return {9'd0, m_time};
         3'd1: return {11'd0, m_date};
         3'd2: return {31'd0, m_en};
         3'd3: return {30'd0, m_snapv, m_pend};
         3'd4: return {9'd0, m_stime};
         3'd5: return {11'd0, m_sdate};
         default: return 32'd0;
      endcase
   endfunction

   function automatic void model_write(input logic [2:0] a, input logic [31:0] d);
      case (a)
         3'd0: begin m_time = d[22:0]; m_pend = 1'b0; m_snapv = 1'b0; end
         3'd1: begin m_date = d[20:0]; m_pend = 1'b0; m_snapv = 1'b0; end
         3'd2: begin
            m_en = d[0];
            if (d[1]) begin
               m_stime = {snap_day_of_week_i, snap_mode_i, snap_hour_i, snap_min_i, snap_sec_i};
               m_sdate = {snap_year_i, snap_month_i, snap_day_of_month_i};
               m_snapv = 1'b1;
            end
         end
         3'd3: if (d[0]) m_pend = 1'b0;
         default: ;
      endcase
   endfunction

   // full transaction with rsp_ready_i high; lat counts cycles from acceptance to rsp_valid_o
   task automatic bus(input logic we, input logic [2:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output int lat);
      int n = 0;
      req_valid_i = 1'b1; req_we_i = we; req_addr_i = a; req_wdata_i = d;
      while (!req_ready_o && n < 20) begin step(); n++; end
      if (!req_ready_o) begin
         checks++; errors++;
         $display("FAIL bus_ready_timeout addr=%0d got ready=0 required 1", a);
      end
      step();
      req_valid_i = 1'b0;
      lat = 1;
      while (!rsp_valid_o && lat < 20) begin step(); lat++; end
      if (!rsp_valid_o) begin
         checks++; errors++;
         $display("FAIL bus_rsp_timeout addr=%0d got rsp_valid=0 required 1", a);
      end
      rd = rsp_rdata_o;
`ifdef RTC_ALARM_HOST_ERR_EN
      last_err = rsp_err_o;
`endif
      if (we) model_write(a, d);
      step();
   endtask

   task automatic test_reset();
      rstn_i = 1'b0;
      model_reset();
      repeat (3) step();
      checks++;
      if ({req_ready_o, rsp_valid_o, snap_req_o, irq_o} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outputs got rdy/vld/snap/irq=%b required 0000",
                  {req_ready_o, rsp_valid_o, snap_req_o, irq_o});
      end
      checks++;
      if ({alarm_day_of_week_o, alarm_mode_o, alarm_hour_o, alarm_min_o, alarm_sec_o,
           alarm_year_o, alarm_month_o, alarm_day_of_month_o} !== 44'd0) begin
         errors++;
         $display("FAIL reset_alarm got nonzero alarm outputs required 0");
      end
      rstn_i = 1'b1;
      checks++;
      if (req_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_ready got %b required 0", req_ready_o);
      end
      step();
      checks++;
      if (req_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_first_clk got %b required 1", req_ready_o);
      end
   endtask

   task automatic test_alarm_rw();
      logic [31:0] rd, d, exp;
      logic [2:0]  a;
      logic        we;
      int          lat;
      bus(1'b1, 3'd0, 32'h0012345, rd, lat);
      checks++;
      if ({alarm_sec_o, alarm_min_o, alarm_hour_o} !== {6'd5, 6'd13, 6'd18}) begin
         errors++;
         $display("FAIL alarm_fields got sec=%0d min=%0d hour=%0d required 5 13 18",
                  alarm_sec_o, alarm_min_o, alarm_hour_o);
      end
      checks++;
      if (lat != 1 || rd !== 32'd0) begin
         errors++;
         $display("FAIL write_rsp got lat=%0d rdata=%h required 1 0", lat, rd);
      end
      bus(1'b0, 3'd0, 32'd0, rd, lat);
      checks++;
      if (rd !== 32'h0012345) begin
         errors++;
         $display("FAIL time_readback got %h required 00012345", rd);
      end
      repeat (30) begin
         a  = 3'($urandom_range(0, 7));
         we = 1'($urandom_range(0, 1));
         d  = $urandom;
         exp = we ? 32'd0 : exp_read(a);
         bus(we, a, d, rd, lat);
         checks++;
         if (rd !== exp) begin
            errors++;
            $display("FAIL rand_access we=%0d addr=%0d got %h required %h", we, a, rd, exp);
         end
         checks++;
         if ({alarm_day_of_week_o, alarm_mode_o, alarm_hour_o, alarm_min_o, alarm_sec_o} !== m_time ||
             {alarm_year_o, alarm_month_o, alarm_day_of_month_o} !== m_date) begin
            errors++;
            $display("FAIL rand_alarm_out got time=%h date=%h required %h %h",
                     {alarm_day_of_week_o, alarm_mode_o, alarm_hour_o, alarm_min_o, alarm_sec_o},
                     {alarm_year_o, alarm_month_o, alarm_day_of_month_o}, m_time, m_date);
         end
      end
   endtask

   task automatic test_irq();
      logic [31:0] rd;
      int          lat;
      bus(1'b1, 3'd3, 32'h1, rd, lat);
      bus(1'b1, 3'd2, 32'h1, rd, lat);
      irq_match_i = 1'b1;
      step(); step();
      m_pend = 1'b1;
      checks++;
      if (irq_o !== 1'b1) begin
         errors++;
         $display("FAIL irq_on_match got %b required 1", irq_o);
      end
      bus(1'b1, 3'd3, 32'h1, rd, lat);
      repeat (5) step();
      checks++;
      if (irq_o !== 1'b0) begin
         errors++;
         $display("FAIL irq_level_held got %b required 0", irq_o);
      end
      bus(1'b0, 3'd3, 32'd0, rd, lat);
      checks++;
      if (rd !== exp_read(3'd3)) begin
         errors++;
         $display("FAIL status_after_w1c got %h required %h", rd, exp_read(3'd3));
      end
      irq_match_i = 1'b0;
      step();
      irq_match_i = 1'b1;
      step(); step();
      m_pend = 1'b1;
      irq_match_i = 1'b0;
      bus(1'b1, 3'd2, 32'h0, rd, lat);
      checks++;
      if (irq_o !== 1'b0) begin
         errors++;
         $display("FAIL irq_en_clear got %b required 0", irq_o);
      end
      bus(1'b0, 3'd3, 32'd0, rd, lat);
      checks++;
      if (rd !== exp_read(3'd3) || rd[0] !== 1'b1) begin
         errors++;
         $display("FAIL pending_kept got %h required %h", rd, exp_read(3'd3));
      end
      bus(1'b1, 3'd3, 32'h1, rd, lat);
      bus(1'b1, 3'd2, 32'h1, rd, lat);
   endtask

   task automatic test_w1c_race();
      logic [31:0] rd;
      int          lat;
      irq_match_i = 1'b1;
      step(); step();
      m_pend = 1'b1;
      irq_match_i = 1'b0;
      step();
      req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 3'd3; req_wdata_i = 32'h1;
      irq_match_i = 1'b1;
      step();
      req_valid_i = 1'b0;
      checks++;
      if (rsp_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL race_rsp got rsp_valid=%b required 1", rsp_valid_o);
      end
      step();
      checks++;
      if (irq_o !== 1'b1) begin
         errors++;
         $display("FAIL race_irq got %b required 1", irq_o);
      end
      bus(1'b0, 3'd3, 32'd0, rd, lat);
      checks++;
      if (rd[0] !== 1'b1) begin
         errors++;
         $display("FAIL race_pending got %h required bit0=1", rd);
      end
      irq_match_i = 1'b0;
      bus(1'b1, 3'd3, 32'h1, rd, lat);
   endtask

   task automatic test_snap();
      logic [31:0] rd;
      int          lat, pulses, rlat;
      snap_sec_i = 6'd30; snap_min_i = 6'd15; snap_hour_i = 6'($urandom_range(0, 23));
      snap_mode_i = 2'($urandom); snap_day_of_week_i = 3'($urandom);
      snap_day_of_month_i = 5'($urandom); snap_month_i = 4'($urandom); snap_year_i = 12'd2030;
      req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 3'd2; req_wdata_i = 32'h3;
      pulses = 0; rlat = 0;
      step();
      req_valid_i = 1'b0;
      model_write(3'd2, 32'h3);
      for (int c = 1; c <= 6; c++) begin
         if (snap_req_o) pulses++;
         if (rsp_valid_o && rlat == 0) rlat = c;
         step();
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL snap_req_pulse got %0d cycles required 1", pulses);
      end
      checks++;
      if (rlat != 3) begin
         errors++;
         $display("FAIL snap_latency got %0d required 3", rlat);
      end
      snap_sec_i = 6'($urandom); snap_year_i = 12'($urandom);
      bus(1'b0, 3'd4, 32'd0, rd, lat);
      checks++;
      if (rd[5:0] !== 6'd30 || rd !== exp_read(3'd4)) begin
         errors++;
         $display("FAIL snap_time got %h required %h", rd, exp_read(3'd4));
      end
      bus(1'b0, 3'd5, 32'd0, rd, lat);
      checks++;
      if (rd[20:9] !== 12'd2030 || rd !== exp_read(3'd5)) begin
         errors++;
         $display("FAIL snap_date got %h required %h", rd, exp_read(3'd5));
      end
      bus(1'b0, 3'd3, 32'd0, rd, lat);
      checks++;
      if (rd[1] !== 1'b1) begin
         errors++;
         $display("FAIL snap_valid got %h required bit1=1", rd);
      end
      bus(1'b1, 3'd1, $urandom, rd, lat);
      bus(1'b0, 3'd3, 32'd0, rd, lat);
      checks++;
      if (rd !== exp_read(3'd3) || rd[1] !== 1'b0) begin
         errors++;
         $display("FAIL snap_valid_clear got %h required %h", rd, exp_read(3'd3));
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd, r0, exp;
      int          lat;
      logic        ok;
      exp = exp_read(3'd1);
      rsp_ready_i = 1'b0;
      req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 3'd1;
      step();
      req_valid_i = 1'b0;
      r0 = rsp_rdata_o;
      checks++;
      if (r0 !== exp) begin
         errors++;
         $display("FAIL stall_rdata got %h required %h", r0, exp);
      end
      ok = 1'b1;
      repeat (5) begin
         step();
         if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== r0 || req_ready_o !== 1'b0) ok = 1'b0;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL stall_hold got vld=%b rdata=%h rdy=%b required 1 %h 0",
                  rsp_valid_o, rsp_rdata_o, req_ready_o, r0);
      end
      rsp_ready_i = 1'b1;
      step();
      checks++;
      if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL stall_release got vld=%b rdy=%b required 0 1", rsp_valid_o, req_ready_o);
      end
      bus(1'b1, 3'd7, $urandom, rd, lat);
      bus(1'b0, 3'd7, 32'd0, rd, lat);
      checks++;
      if (rd !== 32'd0) begin
         errors++;
         $display("FAIL unmapped_read got %h required 0", rd);
      end
`ifdef RTC_ALARM_HOST_ERR_EN
      checks++;
      if (last_err !== 1'b1) begin
         errors++;
         $display("FAIL unmapped_err got %b required 1", last_err);
      end
`else
      bus(1'b0, 3'd6, 32'd0, rd, lat);
      checks++;
      if (rd !== 32'd0) begin
         errors++;
         $display("FAIL addr6_read got %h required 0", rd);
      end
`endif
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      int          lat, seen;
      bus(1'b1, 3'd0, 32'h7FFFFF, rd, lat);
      bus(1'b1, 3'd2, 32'h1, rd, lat);
      irq_match_i = 1'b1;
      step(); step();
      irq_match_i = 1'b0;
      req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 3'd2; req_wdata_i = 32'h3;
      step();
      req_valid_i = 1'b0;
      step();
      #1 rstn_i = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({req_ready_o, rsp_valid_o, snap_req_o, irq_o} !== 4'b0000 ||
          {alarm_day_of_week_o, alarm_mode_o, alarm_hour_o, alarm_min_o, alarm_sec_o} !== 23'd0) begin
         errors++;
         $display("FAIL midreset_outputs got rdy/vld/snap/irq=%b sec=%0d required 0000 0",
                  {req_ready_o, rsp_valid_o, snap_req_o, irq_o}, alarm_sec_o);
      end
      step(); step();
      rstn_i = 1'b1;
      seen = 0;
      repeat (8) begin
         step();
         if (rsp_valid_o) seen++;
      end
      checks++;
      if (seen != 0 || req_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL midreset_no_rsp got rsp cycles=%0d rdy=%b required 0 1", seen, req_ready_o);
      end
      bus(1'b0, 3'd3, 32'd0, rd, lat);
      checks++;
      if (rd !== exp_read(3'd3)) begin
         errors++;
         $display("FAIL midreset_status got %h required %h", rd, exp_read(3'd3));
      end
   endtask

   initial begin
      test_reset();
      test_alarm_rw();
      test_irq();
      test_w1c_race();
      test_snap();
      test_backpressure();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
